// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the programmable synchronous FIFO:
//   fifo_mode_e  - read-port mode (registered read or first-word-fall-through)
//   aw_width()   - address width for a given power-of-two depth
//   cw_width()   - count/threshold width (address width plus one wrap bit)
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int aw_width(input int depth);
    return $clog2(depth);
  endfunction

  // One bit wider than the address so that a completely full FIFO
  // (count == depth) is representable and distinct from empty.
  function automatic int cw_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// One-write / one-read synchronous dual-port RAM with a registered read port.
// A read and a write to the same address in one cycle return the old word.
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata write port
//   i_re/i_raddr        read request and address
//   o_rdata             registered read data, holds when i_re=0
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_we,
  input  logic [aw_width(FIFO_DEPTH)-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0]               i_wdata,
  input  logic                                i_re,
  input  logic [aw_width(FIFO_DEPTH)-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0]               o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // NOTE: the storage array is deliberately left out of reset so it maps onto
  // plain RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_sync_fifo.sv
// -----------------------------------------------------------------------------
// prog_sync_fifo
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// overflow/underflow pulses, synchronous flush and optional FWFT read port.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   clear                       synchronous flush, highest priority
//   wr_en, wr_data              push request and word
//   rd_en, rd_data              pop request and read word
//   afull_thresh/aempty_thresh  almost_full at count>=, almost_empty at count<=
//   full, almost_full, empty, almost_empty   registered status flags
//   overflow, underflow         one-cycle pulse per rejected write / read
//   count                       registered occupancy 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module prog_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FWFT       = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic                               wr_en,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               rd_en,
  output logic [DATA_WIDTH-1:0]              rd_data,
  input  logic [cw_width(FIFO_DEPTH)-1:0]    afull_thresh,
  input  logic [cw_width(FIFO_DEPTH)-1:0]    aempty_thresh,
  output logic                               full,
  output logic                               almost_full,
  output logic                               empty,
  output logic                               almost_empty,
  output logic                               overflow,
  output logic                               underflow,
  output logic [cw_width(FIFO_DEPTH)-1:0]    count
);

  localparam int            AW       = aw_width(FIFO_DEPTH);
  localparam int            CW       = cw_width(FIFO_DEPTH);
  localparam fifo_mode_e    MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0] DEPTH_CW = CW'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  logic [AW:0]           r_wr_ptr, r_rd_ptr;
  logic [AW:0]           w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;
  logic                  w_wr_acc, w_rd_acc;
  logic                  w_byp_hit, r_byp_sel;
  logic [DATA_WIDTH-1:0] r_byp_data;
  logic                  w_mem_re;
  logic [AW-1:0]         w_mem_raddr;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  // A read needs a stored word; a write into a full FIFO is allowed only when
  // a read frees a slot in the same cycle. Flush overrides both.
  assign w_rd_acc = rd_en & ~r_empty & ~clear;
  assign w_wr_acc = wr_en & (~r_full | w_rd_acc) & ~clear;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (clear) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
      if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end
  end

  // With the wrap bit the pointer difference is exact over 0..FIFO_DEPTH.
  assign w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;

  // The word being written becomes the head after this edge exactly when it
  // lands on the next read address, i.e. it is the only entry left. The RAM
  // read in the same cycle would return the stale word, so FWFT bypasses it.
  assign w_byp_hit = w_wr_acc & (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);

  // FWFT keeps the RAM output tracking the next head every cycle; the
  // standard port only reads on an accepted pop and otherwise holds.
  assign w_mem_re    = (MODE == FIFO_FWFT) ? 1'b1 : w_rd_acc;
  assign w_mem_raddr = (MODE == FIFO_FWFT) ? w_rd_ptr_nxt[AW-1:0]
                                           : r_rd_ptr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_byp_sel  <= 1'b0;
      r_byp_data <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      // Flags come from the next count and the live thresholds, so they are
      // valid the cycle after an access or a threshold change.
      r_full    <= (w_count_nxt == DEPTH_CW);
      r_empty   <= (w_count_nxt == '0);
      r_afull   <= (w_count_nxt >= afull_thresh);
      r_aempty  <= (w_count_nxt <= aempty_thresh);
      r_ovf     <= wr_en & ~w_wr_acc & ~clear;
      r_udf     <= rd_en & ~w_rd_acc & ~clear;
      r_byp_sel <= (MODE == FIFO_FWFT) & w_byp_hit;
      if (w_byp_hit) r_byp_data <= wr_data;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (wr_data),
    .i_re    (w_mem_re),
    .i_raddr (w_mem_raddr),
    .o_rdata (w_mem_rdata)
  );

  assign rd_data      = ((MODE == FIFO_FWFT) && r_byp_sel) ? r_byp_data : w_mem_rdata;
  assign full         = r_full;
  assign almost_full  = r_afull;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  assign count        = r_count;

endmodule

// File: tb/tb_prog_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_prog_sync_fifo
// Directed bench for prog_sync_fifo. A standard-mode instance is driven
// through step(); expected read words go into a scoreboard queue that an
// independent monitor drains when a pop completes. A second FWFT instance
// is exercised with hand-computed values.
// -----------------------------------------------------------------------------
module tb_prog_sync_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance
  logic       clear, wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic [4:0] afull_thresh, aempty_thresh, count;
  logic       full, almost_full, empty, almost_empty, overflow, underflow;

  // FWFT instance
  logic       f_clear, f_wr_en, f_rd_en;
  logic [7:0] f_wr_data, f_rd_data;
  logic [4:0] f_afull_thresh, f_aempty_thresh, f_count;
  logic       f_full, f_almost_full, f_empty, f_almost_empty, f_overflow, f_underflow;

  prog_sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .afull_thresh(afull_thresh),
    .aempty_thresh(aempty_thresh), .full(full), .almost_full(almost_full),
    .empty(empty), .almost_empty(almost_empty), .overflow(overflow),
    .underflow(underflow), .count(count)
  );

  prog_sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clear(f_clear), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .afull_thresh(f_afull_thresh),
    .aempty_thresh(f_aempty_thresh), .full(f_full), .almost_full(f_almost_full),
    .empty(f_empty), .almost_empty(f_almost_empty), .overflow(f_overflow),
    .underflow(f_underflow), .count(f_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdl_q[$];   // bench model of FIFO contents
  logic [7:0] exp_q[$];   // scoreboard of expected read words
  bit         sb_rd_pending = 1'b0;
  bit         exp_ovf, exp_udf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop accepted at a rising edge shows its word on rd_data right
  // after that edge.
  initial forever begin
    @(posedge clk);
    if (sb_rd_pending) begin
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underrun: got rd_data 0x%0h, expected no read", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic check_status();
    check("count",        count,        mdl_q.size());
    check("full",         full,         mdl_q.size() == DEPTH);
    check("empty",        empty,        mdl_q.size() == 0);
    check("almost_full",  almost_full,  mdl_q.size() >= int'(afull_thresh));
    check("almost_empty", almost_empty, mdl_q.size() <= int'(aempty_thresh));
    check("overflow",     overflow,     exp_ovf);
    check("underflow",    underflow,    exp_udf);
  endtask

  // One clock of stimulus on the standard instance, entered and left at a
  // falling edge.
  task automatic step(input bit clr, input bit wr, input logic [7:0] wd, input bit rd);
    bit rd_acc, wr_acc;
    rd_acc  = rd && !clr && (mdl_q.size() != 0);
    wr_acc  = wr && !clr && ((mdl_q.size() < DEPTH) || rd_acc);
    exp_ovf = wr && !clr && !wr_acc;
    exp_udf = rd && !clr && !rd_acc;
    clear = clr; wr_en = wr; wr_data = wd; rd_en = rd;
    sb_rd_pending = rd_acc;
    if (rd_acc) exp_q.push_back(mdl_q.pop_front());
    if (clr)    mdl_q.delete();
    if (wr_acc) mdl_q.push_back(wd);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; sb_rd_pending = 1'b0;
    check_status();
  endtask

  task automatic f_cycle(input bit wr, input logic [7:0] wd, input bit rd);
    f_wr_en = wr; f_wr_data = wd; f_rd_en = rd;
    @(posedge clk);
    @(negedge clk);
    f_wr_en = 1'b0; f_rd_en = 1'b0;
  endtask

  initial begin
    clear = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    afull_thresh = 5'd12; aempty_thresh = 5'd3;
    f_clear = 0; f_wr_en = 0; f_rd_en = 0; f_wr_data = '0;
    f_afull_thresh = 5'd12; f_aempty_thresh = 5'd3;
    exp_ovf = 0; exp_udf = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_aempty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_f_empty", f_empty, 1);
    rst_n = 1'b1;

    // Read while empty: one underflow pulse, nothing changes
    step(0, 0, 8'h00, 1);
    check("udf_pulse", underflow, 1);
    check("udf_empty", empty, 1);
    step(0, 0, 8'h00, 0);
    check("udf_gone", underflow, 0);

    // Fill 0x00..0x0F; almost_full must rise exactly at count 12
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 8'(i), 0);
      if (i == 10) check("afull_at_11", almost_full, 0);
      if (i == 11) check("afull_at_12", almost_full, 1);
    end
    step(0, 1, 8'hFF, 0);
    check("ovf_pulse", overflow, 1);
    check("ovf_full", full, 1);
    check("ovf_count", count, 16);
    step(0, 0, 8'h00, 0);
    check("ovf_gone", overflow, 0);

    // Full with simultaneous read+write: pops 0x00..0x03, count stays 16
    for (int i = 0; i < 4; i++) step(0, 1, 8'h10 + 8'(i), 1);
    check("rw_full_count", count, 16);

    // Drain to 3 (pops 0x04..0x0F, 0x10)
    for (int i = 0; i < 13; i++) step(0, 0, 8'h00, 1);
    check("drain_count", count, 3);
    check("aempty_at_3", almost_empty, 1);
    check("afull_at_3", almost_full, 0);

    // Threshold changes with no access
    afull_thresh = 5'd2;
    step(0, 0, 8'h00, 0);
    check("afull_thr_2", almost_full, 1);
    afull_thresh = 5'd0; aempty_thresh = 5'd16;
    step(0, 0, 8'h00, 0);
    check("afull_thr_0", almost_full, 1);
    check("aempty_thr_16", almost_empty, 1);
    afull_thresh = 5'd12; aempty_thresh = 5'd3;
    step(0, 0, 8'h00, 0);

    // Grow to 9, then clear together with a write
    for (int i = 0; i < 6; i++) step(0, 1, 8'h20 + 8'(i), 0);
    check("pre_clear_count", count, 9);
    step(1, 1, 8'hEE, 0);
    check("clear_count", count, 0);
    check("clear_empty", empty, 1);
    step(0, 1, 8'h55, 0);
    step(0, 0, 8'h00, 1);   // scoreboard expects 0x55, not 0xEE

    // FWFT: word written into an empty FIFO is visible one cycle later
    f_cycle(1, 8'hA5, 0);
    check("fwft_empty", f_empty, 0);
    check("fwft_data_a5", f_rd_data, 8'hA5);
    f_cycle(1, 8'h3C, 0);
    check("fwft_hold_a5", f_rd_data, 8'hA5);
    check("fwft_count2", f_count, 2);
    f_cycle(0, 8'h00, 1);
    check("fwft_pop_3c", f_rd_data, 8'h3C);
    f_cycle(1, 8'h77, 1);   // sole entry popped while a new one arrives
    check("fwft_byp_77", f_rd_data, 8'h77);
    check("fwft_count1", f_count, 1);
    f_cycle(0, 8'h00, 1);
    check("fwft_drained", f_empty, 1);

    // Asynchronous reset in the middle of a write burst
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 0);
    wr_en = 1'b1; wr_data = 8'h03;
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_aempty", almost_empty, 1);
    check("arst_full", full, 0);
    check("arst_afull", almost_full, 0);
    check("arst_ovf", overflow, 0);
    check("arst_udf", underflow, 0);
    check("arst_rd_data", rd_data, 8'h00);
    mdl_q.delete();
    wr_en = 1'b0;
    exp_ovf = 0; exp_udf = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Resumes immediately after reset
    step(0, 1, 8'h9A, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
